pwm_controller: RTL and testbench

PWM_CONTROLLER -- requirements
Module: pwm_controller

---
 rtl/pwm_ctrl_pkg.sv | 37 +++
 rtl/pwm_prescaler.sv | 39 +++
 rtl/pwm_controller.sv | 195 +++++++++++++++++++
 tb/tb_pwm_controller.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwm_ctrl_pkg
// Description : Shared types and constants for the 16-channel PWM controller:
//               FSM state encoding, phase wrap value, output count and the
//               per-output level function used by the output register.
// Revision    : 1.0 - initial release
// ============================================================================
package pwm_ctrl_pkg;

  // Controller run state: IDLE holds everything at zero, RUN drives outputs
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Last phase value of a period; phase wraps 254 -> 0 (255 ticks per period)
  localparam logic [7:0] PHASE_MAX = 8'd254;

  // Number of driven outputs
  localparam int NUM_OUT = 16;

  // Output level for every channel given the shadow configuration and phase:
  // disabled -> 0, enabled static -> 1, enabled PWM -> (phase < duty)
  function automatic logic [NUM_OUT-1:0] pwm_level_vec(
    input logic [NUM_OUT-1:0] en_out,
    input logic [NUM_OUT-1:0] en_pwm,
    input logic [7:0]         duty,
    input logic [7:0]         phase
  );
    logic lvl;
    lvl = (phase < duty);
    return en_out & (~en_pwm | {NUM_OUT{lvl}});
  endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : pwm_prescaler
// Description : Free-running modulo-PRESCALE counter producing a one-cycle
//               phase tick when the count reaches PRESCALE-1. A synchronous
//               clear holds the count at zero.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_prescaler #(
  parameter int PRESCALE = 3000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  // PRESCALE is at least 2, so the counter is at least one bit wide
  localparam int            CW   = $clog2(PRESCALE);
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] count;

  // Count 0..PRESCALE-1, wrapping on the terminal count; clear wins
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  // Tick is decoded from the count so it lines up with the terminal value
  assign tick = (count == LAST);

endmodule
`default_nettype wire

// File: rtl/pwm_controller.sv
`default_nettype none
// ============================================================================
// Module      : pwm_controller
// Description : 16-output PWM controller. Configuration from the SPI register
//               file is captured into shadow registers; outputs are driven
//               from the shadows only, so input changes between loads are
//               invisible. A 255-tick phase counter, advanced by the
//               prescaler tick, sets the PWM period.
//               Build option PWM_CTRL_GLITCHFREE_EN: when defined, writes in
//               RUN are deferred to the next period wrap (coalesced into one
//               pending update); when undefined, writes in RUN load on the
//               next edge without disturbing the phase.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_controller
  import pwm_ctrl_pkg::*;
#(
  parameter int PRESCALE = 3000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         en_reg_out_7_0,
  input  logic [7:0]         en_reg_out_15_8,
  input  logic [7:0]         en_reg_pwm_7_0,
  input  logic [7:0]         en_reg_pwm_15_8,
  input  logic [7:0]         pwm_duty_cycle,
  input  logic               cfg_valid,
  output logic               cfg_ack,
  output logic [NUM_OUT-1:0] pwm_out,
  output logic               period_start
);

  // Live configuration as seen on the register file
  logic [NUM_OUT-1:0] en_out_in;
  logic [NUM_OUT-1:0] en_pwm_in;

  assign en_out_in = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm_in = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  // State and shadow registers with their next values
  state_t             state,      state_nx;
  logic [7:0]         phase,      phase_nx;
  logic [NUM_OUT-1:0] en_out_sh,  en_out_nx;
  logic [NUM_OUT-1:0] en_pwm_sh,  en_pwm_nx;
  logic [7:0]         duty_sh,    duty_nx;
  logic [NUM_OUT-1:0] pwm_nx;
  logic               ack_nx;
  logic               ps_nx;
`ifdef PWM_CTRL_GLITCHFREE_EN
  logic               pending,    pending_nx;
`endif

  // Prescaler interface
  logic presc_tick;
  logic presc_clr;
  logic tick;
  logic wrap;
  logic load;

  pwm_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (presc_clr),
    .tick (presc_tick)
  );

  // Ticks only advance the phase while running; wrap marks the 254 -> 0 step
  assign tick = presc_tick && (state == RUN);
  assign wrap = tick && (phase == PHASE_MAX);

  // State, counters, shadows and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      phase        <= 8'd0;
      en_out_sh    <= '0;
      en_pwm_sh    <= '0;
      duty_sh      <= 8'd0;
      pwm_out      <= '0;
      cfg_ack      <= 1'b0;
      period_start <= 1'b0;
`ifdef PWM_CTRL_GLITCHFREE_EN
      pending      <= 1'b0;
`endif
    end else begin
      state        <= state_nx;
      phase        <= phase_nx;
      en_out_sh    <= en_out_nx;
      en_pwm_sh    <= en_pwm_nx;
      duty_sh      <= duty_nx;
      pwm_out      <= pwm_nx;
      cfg_ack      <= ack_nx;
      period_start <= ps_nx;
`ifdef PWM_CTRL_GLITCHFREE_EN
      pending      <= pending_nx;
`endif
    end
  end

  // Next-state, shadow-load decision and next output values
  always_comb begin
    state_nx   = state;
    phase_nx   = phase;
    en_out_nx  = en_out_sh;
    en_pwm_nx  = en_pwm_sh;
    duty_nx    = duty_sh;
    ack_nx     = 1'b0;
    ps_nx      = 1'b0;
    load       = 1'b0;
    presc_clr  = 1'b0;
`ifdef PWM_CTRL_GLITCHFREE_EN
    pending_nx = pending;
`endif

    case (state)
      IDLE: begin
        // Counters parked at zero so a start always begins a fresh period
        presc_clr = 1'b1;
        phase_nx  = 8'd0;
`ifdef PWM_CTRL_GLITCHFREE_EN
        pending_nx = 1'b0;
`endif
        if (cfg_valid) begin
          load = 1'b1;
          if (en_out_in != '0) begin
            state_nx = RUN;
            ps_nx    = 1'b1;
          end
        end
      end

      RUN: begin
        if (tick) begin
          phase_nx = wrap ? 8'd0 : phase + 8'd1;
        end
        if (wrap) begin
          ps_nx = 1'b1;
        end

`ifdef PWM_CTRL_GLITCHFREE_EN
        // Writes wait for the wrap; a write on the wrap cycle itself is
        // consumed by that wrap and never becomes pending
        if (wrap) begin
          pending_nx = 1'b0;
          if (pending || cfg_valid) begin
            load = 1'b1;
          end
        end else if (cfg_valid) begin
          pending_nx = 1'b1;
        end
`else
        // Immediate update: shadows change, phase keeps running
        if (cfg_valid) begin
          load = 1'b1;
        end
`endif

        // Loading an all-disabled configuration stops the controller
        if (load && (en_out_in == '0)) begin
          state_nx  = IDLE;
          phase_nx  = 8'd0;
          presc_clr = 1'b1;
`ifdef PWM_CTRL_GLITCHFREE_EN
          pending_nx = 1'b0;
`endif
        end
      end

      default: begin
        state_nx  = IDLE;
        phase_nx  = 8'd0;
        presc_clr = 1'b1;
      end
    endcase

    if (load) begin
      en_out_nx = en_out_in;
      en_pwm_nx = en_pwm_in;
      duty_nx   = pwm_duty_cycle;
      ack_nx    = 1'b1;
    end

    // Output is computed from the values taking effect at this edge so that
    // a phase step shows on pwm_out one clock after the tick that caused it
    if (state_nx == RUN) begin
      pwm_nx = pwm_level_vec(en_out_nx, en_pwm_nx, duty_nx, phase_nx);
    end else begin
      pwm_nx = '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pwm_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_controller
// Description : Directed, table-driven bench for pwm_controller at
//               PRESCALE=4 (255-tick period = 1020 clk), plus hand-written
//               sequences for wrap reloads, in-period updates, reset in the
//               middle of a period and stop-by-disable.
//               Build option PWM_CTRL_GLITCHFREE_EN selects the expected
//               in-period update behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_controller;

  localparam int PRESCALE = 4;
  localparam int PERIOD   = 1020;
`ifdef PWM_CTRL_GLITCHFREE_EN
  localparam bit GF = 1'b1;
`else
  localparam bit GF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  en_reg_out_7_0  = 8'h00;
  logic [7:0]  en_reg_out_15_8 = 8'h00;
  logic [7:0]  en_reg_pwm_7_0  = 8'h00;
  logic [7:0]  en_reg_pwm_15_8 = 8'h00;
  logic [7:0]  pwm_duty_cycle  = 8'h00;
  logic        cfg_valid = 1'b0;
  logic        cfg_ack;
  logic [15:0] pwm_out;
  logic        period_start;

  pwm_controller #(.PRESCALE(PRESCALE)) dut (
    .clk             (clk),
    .rst             (rst),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .cfg_valid       (cfg_valid),
    .cfg_ack         (cfg_ack),
    .pwm_out         (pwm_out),
    .period_start    (period_start)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  int hi_cnt[16];
  int ack_cnt;
  int ps_cnt;

  typedef struct {
    logic [15:0] en_out;
    logic [15:0] en_pwm;
    logic [7:0]  duty;
    int          pwm_cycles;   // high clk per period for a PWM-mode channel
    logic        run;          // controller expected to enter RUN
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_n(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic set_cfg(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
    en_reg_out_7_0  = eo[7:0];
    en_reg_out_15_8 = eo[15:8];
    en_reg_pwm_7_0  = ep[7:0];
    en_reg_pwm_15_8 = ep[15:8];
    pwm_duty_cycle  = d;
  endtask

  // One-cycle write strobe; returns in the cycle after the load edge
  task automatic pulse_cfg();
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    rst       = 1'b1;
    cfg_valid = 1'b0;
    step_n(2);
    check({tag, "_rst_pwm"}, 32'(pwm_out), 32'h0);
    check({tag, "_rst_ack"}, 32'(cfg_ack), 32'h0);
    check({tag, "_rst_ps"},  32'(period_start), 32'h0);
    rst = 1'b0;
  endtask

  // Sample one full period starting at the current cycle
  task automatic run_period(input bit scramble);
    for (int b = 0; b < 16; b++) hi_cnt[b] = 0;
    ack_cnt = 0;
    ps_cnt  = 0;
    for (int c = 0; c < PERIOD; c++) begin
      for (int b = 0; b < 16; b++) hi_cnt[b] += int'(pwm_out[b]);
      ack_cnt += int'(cfg_ack);
      ps_cnt  += int'(period_start);
      if (scramble) set_cfg(16'($urandom), 16'($urandom), 8'($urandom));
      step();
    end
  endtask

  initial begin
    int acks;
    int n;
    int hi;
    int bad;
    int exp_b;

    //               en_out    en_pwm    duty   pwm_cycles run
    vecs[0] = '{16'h0001, 16'h0001, 8'h80, 512,  1'b1};
    vecs[1] = '{16'h0001, 16'h0001, 8'h00, 0,    1'b1};
    vecs[2] = '{16'h0001, 16'h0001, 8'hFF, 1020, 1'b1};
    vecs[3] = '{16'hFFFF, 16'h00FF, 8'h40, 256,  1'b1};
    vecs[4] = '{16'hA5C3, 16'h0F0F, 8'h01, 4,    1'b1};
    vecs[5] = '{16'h0000, 16'hFFFF, 8'h80, 0,    1'b0};

    // Table: load from IDLE, then measure one period with noisy inputs
    for (int i = 0; i < 6; i++) begin
      do_reset($sformatf("v%0d", i));
      set_cfg(vecs[i].en_out, vecs[i].en_pwm, vecs[i].duty);
      pulse_cfg();
      check($sformatf("v%0d_ack", i), 32'(cfg_ack), 32'h1);
      check($sformatf("v%0d_ps", i), 32'(period_start), 32'(vecs[i].run));
      run_period(1'b1);
      check($sformatf("v%0d_ack_count", i), 32'(ack_cnt), 32'd1);
      check($sformatf("v%0d_ps_count", i), 32'(ps_cnt), 32'(vecs[i].run));
      for (int b = 0; b < 16; b++) begin
        if (!vecs[i].en_out[b])      exp_b = 0;
        else if (!vecs[i].en_pwm[b]) exp_b = PERIOD;
        else                         exp_b = vecs[i].pwm_cycles;
        check($sformatf("v%0d_hi_bit%0d", i, b), 32'(hi_cnt[b]), 32'(exp_b));
      end
      check($sformatf("v%0d_next_ps", i), 32'(period_start), 32'(vecs[i].run));
    end

    // Duty 0x00 for a period, then 0xFF loaded exactly at the wrap tick
    do_reset("seqA");
    set_cfg(16'h0001, 16'h0001, 8'h00);
    pulse_cfg();
    hi = 0;
    for (int c = 0; c < PERIOD - 1; c++) begin
      hi += int'(pwm_out[0]);
      step();
    end
    hi += int'(pwm_out[0]);
    check("seqA_duty00_hi", 32'(hi), 32'd0);
    set_cfg(16'h0001, 16'h0001, 8'hFF);
    pulse_cfg();
    check("seqA_wrap_ack", 32'(cfg_ack), 32'h1);
    check("seqA_wrap_ps", 32'(period_start), 32'h1);
    run_period(1'b0);
    check("seqA_dutyFF_hi", 32'(hi_cnt[0]), 32'(PERIOD));
    check("seqA_ps_count", 32'(ps_cnt), 32'd1);
    check("seqA_next_ps", 32'(period_start), 32'h1);

    // Three writes in the middle of a period (phase 10), duty 0x10
    do_reset("seqB");
    set_cfg(16'h0001, 16'h0001, 8'h80);
    pulse_cfg();
    step_n(41);
    set_cfg(16'h0001, 16'h0001, 8'h10);
    acks = 0;
    for (int k = 0; k < 6; k++) begin
      cfg_valid = (k % 2 == 0);
      step();
      acks += int'(cfg_ack);
    end
    cfg_valid = 1'b0;
    check("seqB_mid_acks", 32'(acks), GF ? 32'd0 : 32'd3);
    step_n(34);
    check("seqB_phase20_pwm", 32'(pwm_out[0]), GF ? 32'h1 : 32'h0);
    acks = 0;
    n    = 0;
    while (!period_start && n < 1100) begin
      acks += int'(cfg_ack);
      step();
      n++;
    end
    check("seqB_wrap_reached", 32'(period_start), 32'h1);
    check("seqB_wrap_delay", 32'(n), 32'd939);
    check("seqB_pre_wrap_acks", 32'(acks), 32'd0);
    check("seqB_wrap_ack", 32'(cfg_ack), GF ? 32'h1 : 32'h0);
    run_period(1'b0);
    check("seqB_new_duty_hi", 32'(hi_cnt[0]), 32'd64);
    check("seqB_period_acks", 32'(ack_cnt), GF ? 32'd1 : 32'd0);

    // Reset at phase 100, with a simultaneous write that must be ignored
    do_reset("seqC");
    set_cfg(16'hFFFF, 16'hFFFF, 8'h80);
    pulse_cfg();
    step_n(401);
    check("seqC_phase100_pwm", 32'(pwm_out), 32'hFFFF);
    rst       = 1'b1;
    cfg_valid = 1'b1;
    step();
    rst       = 1'b0;
    cfg_valid = 1'b0;
    check("seqC_after_rst_pwm", 32'(pwm_out), 32'h0);
    check("seqC_after_rst_ack", 32'(cfg_ack), 32'h0);
    check("seqC_after_rst_ps", 32'(period_start), 32'h0);
    ps_cnt = 0; ack_cnt = 0; bad = 0;
    for (int c = 0; c < 1100; c++) begin
      step();
      ps_cnt  += int'(period_start);
      ack_cnt += int'(cfg_ack);
      bad     += int'(pwm_out != 16'h0);
    end
    check("seqC_idle_ps", 32'(ps_cnt), 32'd0);
    check("seqC_idle_ack", 32'(ack_cnt), 32'd0);
    check("seqC_idle_pwm", 32'(bad), 32'd0);
    pulse_cfg();
    check("seqC_restart_ack", 32'(cfg_ack), 32'h1);
    check("seqC_restart_ps", 32'(period_start), 32'h1);
    check("seqC_restart_pwm", 32'(pwm_out), 32'hFFFF);

    // Disable everything at a wrap, then restart and confirm a fresh period
    do_reset("seqD");
    set_cfg(16'hFFFF, 16'h0000, 8'h80);
    pulse_cfg();
    step_n(PERIOD - 1);
    check("seqD_pre_wrap_pwm", 32'(pwm_out), 32'hFFFF);
    set_cfg(16'h0000, 16'h0000, 8'h80);
    pulse_cfg();
    check("seqD_stop_ack", 32'(cfg_ack), 32'h1);
    check("seqD_stop_pwm", 32'(pwm_out), 32'h0);
    ps_cnt = 0; bad = 0;
    for (int c = 0; c < 1100; c++) begin
      step();
      ps_cnt += int'(period_start);
      bad    += int'(pwm_out != 16'h0);
    end
    check("seqD_idle_ps", 32'(ps_cnt), 32'd0);
    check("seqD_idle_pwm", 32'(bad), 32'd0);
    set_cfg(16'h0001, 16'h0001, 8'h80);
    pulse_cfg();
    check("seqD_restart_ps", 32'(period_start), 32'h1);
    run_period(1'b0);
    check("seqD_restart_hi", 32'(hi_cnt[0]), 32'd512);
    check("seqD_restart_ps_count", 32'(ps_cnt), 32'd1);
    check("seqD_restart_next_ps", 32'(period_start), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
